// File: rtl/noekeon_pkg.sv
// Shared definitions for the two-channel Noekeon core arbiter.
package noekeon_pkg;

  localparam int NK_KW        = 128;
  localparam int NK_OP_CYCLES = 17;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEY_ISSUE,
    ST_KEY_WAIT,
    ST_DATA_ISSUE,
    ST_DATA_WAIT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/noekeon_rr_arb.sv
// Two-input round-robin picker: on a tie the channel that did not win last time is chosen.
module noekeon_rr_arb (
  input  logic [1:0] eligible,
  input  logic       last_grant,
  output logic       valid,
  output logic       ch
);

  assign valid = |eligible;
  assign ch    = (&eligible) ? ~last_grant : eligible[1];

endmodule

// File: rtl/noekeon_arbiter.sv
// Shares one Noekeon core between two requesters; the core key is reloaded only
// when the owning channel changes or its stored key was rewritten.
module noekeon_arbiter
  import noekeon_pkg::*;
#(
  parameter int KW = NK_KW
) (
  input  logic            inClk,
  input  logic            inReset,
  input  logic [1:0]      inKeyWr,
  input  logic [1:0]      inKeyMode,
  input  logic [2*KW-1:0] inKey,
  input  logic [1:0]      inReq,
  input  logic [1:0]      inDecipher,
  input  logic [2*KW-1:0] inData,
  output logic [1:0]      outGrant,
  output logic [1:0]      outDone,
  output logic [KW-1:0]   outResult,
  output logic            outBusy,
  output logic            outCoreKeyWr,
  output logic            outCoreMode,
  output logic [KW-1:0]   outCoreKey,
  output logic            outCoreDataWr,
  output logic            outCoreDecipher,
  output logic [KW-1:0]   outCoreData,
  input  logic            inCoreBusy,
  input  logic [KW-1:0]   inCoreResult
);

  state_t        state;
  logic [KW-1:0] key_q [2];
  logic [1:0]    mode_q;
  logic [1:0]    key_valid;
  logic          owner, owner_valid, last_grant, cur;

  logic [KW-1:0] key_now [2];
  logic [1:0]    mode_now, eligible;
  logic          pick_valid, pick_ch, need_reload;

  // A key written on the same edge as the grant must be the one sent to the core.
  assign key_now[0]  = inKeyWr[0] ? inKey[KW-1:0]    : key_q[0];
  assign key_now[1]  = inKeyWr[1] ? inKey[2*KW-1:KW] : key_q[1];
  assign mode_now    = (inKeyWr & inKeyMode) | (~inKeyWr & mode_q);
  assign eligible    = inReq & (key_valid | inKeyWr);
  assign need_reload = !(owner_valid && owner == pick_ch) || inKeyWr[pick_ch];

  noekeon_rr_arb u_rr_arb (
    .eligible   (eligible),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .ch         (pick_ch)
  );

  // NOTE: key storage is deliberately not reset; key_valid gates every use of it.
  always_ff @(posedge inClk) begin
    if (inKeyWr[0]) begin
      key_q[0]  <= inKey[KW-1:0];
      mode_q[0] <= inKeyMode[0];
    end
    if (inKeyWr[1]) begin
      key_q[1]  <= inKey[2*KW-1:KW];
      mode_q[1] <= inKeyMode[1];
    end
  end

  always_ff @(posedge inClk or posedge inReset) begin
    if (inReset) begin
      state           <= ST_IDLE;
      key_valid       <= 2'b00;
      owner           <= 1'b0;
      owner_valid     <= 1'b0;
      last_grant      <= 1'b1;
      cur             <= 1'b0;
      outGrant        <= 2'b00;
      outDone         <= 2'b00;
      outResult       <= '0;
      outBusy         <= 1'b0;
      outCoreKeyWr    <= 1'b0;
      outCoreMode     <= 1'b0;
      outCoreKey      <= '0;
      outCoreDataWr   <= 1'b0;
      outCoreDecipher <= 1'b0;
      outCoreData     <= '0;
    end else begin
      outGrant      <= 2'b00;
      outDone       <= 2'b00;
      outCoreKeyWr  <= 1'b0;
      outCoreDataWr <= 1'b0;
      key_valid     <= key_valid | inKeyWr;

      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            cur             <= pick_ch;
            last_grant      <= pick_ch;
            outGrant        <= pick_ch ? 2'b10 : 2'b01;
            outBusy         <= 1'b1;
            outCoreData     <= pick_ch ? inData[2*KW-1:KW] : inData[KW-1:0];
            outCoreDecipher <= inDecipher[pick_ch];
            if (need_reload) begin
              state        <= ST_KEY_ISSUE;
              outCoreKeyWr <= 1'b1;
              outCoreKey   <= key_now[pick_ch];
              outCoreMode  <= mode_now[pick_ch];
            end else begin
              state         <= ST_DATA_ISSUE;
              outCoreDataWr <= 1'b1;
            end
          end
        end
        ST_KEY_ISSUE: begin
          owner       <= cur;
          owner_valid <= !inKeyWr[cur];
          if (outCoreMode) begin
            state <= ST_KEY_WAIT;
          end else begin
            state         <= ST_DATA_ISSUE;
            outCoreDataWr <= 1'b1;
          end
        end
        ST_KEY_WAIT: begin
          if (!inCoreBusy) begin
            state         <= ST_DATA_ISSUE;
            outCoreDataWr <= 1'b1;
          end
        end
        ST_DATA_ISSUE: state <= ST_DATA_WAIT;
        ST_DATA_WAIT: begin
          if (!inCoreBusy) begin
            state     <= ST_DONE;
            outResult <= inCoreResult;
            outDone   <= cur ? 2'b10 : 2'b01;
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          outBusy <= 1'b0;
        end
        default: begin
          state   <= ST_IDLE;
          outBusy <= 1'b0;
        end
      endcase

      // NOTE: this later assignment overrides any owner_valid update from the case above.
      if (state != ST_KEY_ISSUE && owner_valid && inKeyWr[owner])
        owner_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_noekeon_arbiter.sv
// Directed bench for noekeon_arbiter with a behavioural core model that mixes key into data.
module tb_noekeon_arbiter;
  import noekeon_pkg::*;

  localparam int KW = NK_KW;

  logic            clk, rst;
  logic [1:0]      key_wr, key_mode, req, decipher;
  logic [2*KW-1:0] key, data;
  logic [1:0]      grant, done;
  logic [KW-1:0]   result, core_key, core_data, core_result;
  logic            busy, core_kwr, core_mode, core_dwr, core_dec, core_busy;

  noekeon_arbiter #(.KW(KW)) dut (
    .inClk(clk), .inReset(rst), .inKeyWr(key_wr), .inKeyMode(key_mode), .inKey(key),
    .inReq(req), .inDecipher(decipher), .inData(data), .outGrant(grant), .outDone(done),
    .outResult(result), .outBusy(busy), .outCoreKeyWr(core_kwr), .outCoreMode(core_mode),
    .outCoreKey(core_key), .outCoreDataWr(core_dwr), .outCoreDecipher(core_dec),
    .outCoreData(core_data), .inCoreBusy(core_busy), .inCoreResult(core_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [KW-1:0] f(input logic [KW-1:0] k, input logic [KW-1:0] d, input logic dec);
    return dec ? ~(d ^ k) : (d ^ {k[63:0], k[127:64]});
  endfunction

  // Core model: busy for NK_OP_CYCLES starting the cycle after a data or indirect-key strobe.
  logic [KW-1:0] ckey, cres;
  int            bcnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ckey <= '0; cres <= '0; bcnt <= 0;
    end else begin
      if (bcnt != 0) bcnt <= bcnt - 1;
      if (core_kwr) begin
        ckey <= core_key;
        if (core_mode) bcnt <= NK_OP_CYCLES;
      end
      if (core_dwr) begin
        cres <= f(ckey, core_data, core_dec);
        bcnt <= NK_OP_CYCLES;
      end
    end
  end
  assign core_busy   = (bcnt != 0);
  assign core_result = cres;

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  int            c0, own, kwr_n;
  int            g_cyc [2], d_cyc [2], kwr_cyc [2], dwr_cyc [2];
  logic          kwr_mode [2];
  logic [KW-1:0] kwr_key [2], res [2];

  task automatic clear_log();
    kwr_n = 0; own = 0;
    for (int i = 0; i < 2; i++) begin
      g_cyc[i] = -1; d_cyc[i] = -1; kwr_cyc[i] = -1; dwr_cyc[i] = -1;
      kwr_mode[i] = 1'bx; kwr_key[i] = 'x; res[i] = 'x;
    end
  endtask

  task automatic write_key(input int ch, input logic mode, input logic [KW-1:0] k);
    key_wr[ch] = 1'b1;
    key_mode[ch] = mode;
    if (ch == 1) key[2*KW-1:KW] = k; else key[KW-1:0] = k;
    @(negedge clk);
    key_wr = 2'b00;
  endtask

  // Watches the DUT each negedge, logging event cycles relative to c0, until the
  // channels in mask complete (mask 0: watch for the whole budget).
  task automatic run(input logic [1:0] mask, input int kw_at, input int kw_ch,
                     input logic kw_mode, input logic [KW-1:0] kw_key, input int budget);
    logic [1:0] seen;
    int rel;
    seen = 2'b00;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      rel = cyc - c0;
      key_wr = 2'b00;
      if (rel == kw_at) begin
        key_wr[kw_ch] = 1'b1;
        key_mode[kw_ch] = kw_mode;
        if (kw_ch == 1) key[2*KW-1:KW] = kw_key; else key[KW-1:0] = kw_key;
      end
      for (int i = 0; i < 2; i++)
        if (grant[i]) begin g_cyc[i] = rel; own = i; req[i] = 1'b0; end
      if (core_kwr) begin
        kwr_n++; kwr_cyc[own] = rel; kwr_mode[own] = core_mode; kwr_key[own] = core_key;
      end
      if (core_dwr) dwr_cyc[own] = rel;
      for (int i = 0; i < 2; i++)
        if (done[i]) begin d_cyc[i] = rel; res[i] = result; seen[i] = 1'b1; end
      if (mask != 2'b00 && (seen & mask) == mask) break;
    end
    key_wr = 2'b00;
    if (mask != 2'b00 && (seen & mask) != mask) check("timeout", seen, mask);
  endtask

  localparam logic [KW-1:0] K0 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  localparam logic [KW-1:0] K1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [KW-1:0] K2 = 128'hdead_beef_cafe_f00d_0bad_c0de_1234_5678;
  localparam logic [KW-1:0] K3 = 128'ha5a5_a5a5_5a5a_5a5a_0f0f_0f0f_f0f0_f0f0;
  localparam logic [KW-1:0] K4 = 128'h8000_0000_0000_0001_7fff_ffff_ffff_fffe;
  localparam logic [KW-1:0] D0 = 128'h0000_0000_0000_0000_0000_0000_0000_0001;
  localparam logic [KW-1:0] D1 = 128'hffff_0000_ffff_0000_ffff_0000_ffff_0000;
  localparam logic [KW-1:0] D2 = 128'h1357_9bdf_2468_ace0_1357_9bdf_2468_ace0;
  localparam logic [KW-1:0] D3 = 128'h0f1e_2d3c_4b5a_6978_8796_a5b4_c3d2_e1f0;
  localparam logic [KW-1:0] D4 = 128'h7777_6666_5555_4444_3333_2222_1111_0000;
  localparam logic [KW-1:0] D5 = 128'h0102_0304_0506_0708_090a_0b0c_0d0e_0f10;
  localparam logic [KW-1:0] D6 = 128'hf0e0_d0c0_b0a0_9080_7060_5040_3020_1000;

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctl"}, {grant, done, busy, core_kwr, core_mode, core_dwr, core_dec}, '0);
    check({tag, "_res"}, result, '0);
    check({tag, "_bus"}, {core_key, core_data}, '0);
  endtask

  initial begin
    rst = 1'b1; key_wr = '0; key_mode = '0; key = '0; req = '0; decipher = '0; data = '0;
    clear_log();
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("post_reset");

    // Direct key on ch0, first request reloads the core.
    write_key(0, 1'b0, K0);
    clear_log(); req[0] = 1'b1; decipher[0] = 1'b0; data[KW-1:0] = D0; c0 = cyc;
    run(2'b01, -1, 0, 1'b0, '0, 100);
    check("t1_grant", g_cyc[0], 1);
    check("t1_keywr", kwr_cyc[0], 1);
    check("t1_keymode", kwr_mode[0], 1'b0);
    check("t1_key", kwr_key[0], K0);
    check("t1_datawr", dwr_cyc[0], 2);
    check("t1_done", d_cyc[0], 21);
    check("t1_result", res[0], f(K0, D0, 1'b0));

    // Back-to-back from the DONE cycle: sampled in the next IDLE, no reload.
    clear_log(); req[0] = 1'b1; decipher[0] = 1'b1; data[KW-1:0] = D1; c0 = cyc;
    run(2'b01, -1, 0, 1'b0, '0, 100);
    check("t2_grant", g_cyc[0], 2);
    check("t2_keywr_n", kwr_n, 0);
    check("t2_datawr", dwr_cyc[0], 2);
    check("t2_done", d_cyc[0], 21);
    check("t2_result", res[0], f(K0, D1, 1'b1));

    // Key rewrite during DATA_WAIT: current op keeps the old key, next op reloads.
    @(negedge clk);
    clear_log(); req[0] = 1'b1; decipher[0] = 1'b0; data[KW-1:0] = D2; c0 = cyc;
    run(2'b01, 5, 0, 1'b0, K2, 100);
    check("t5_keywr_n", kwr_n, 0);
    check("t5_done", d_cyc[0], 20);
    check("t5_result", res[0], f(K0, D2, 1'b0));
    @(negedge clk);
    clear_log(); req[0] = 1'b1; data[KW-1:0] = D3; c0 = cyc;
    run(2'b01, -1, 0, 1'b0, '0, 100);
    check("t5b_keywr", kwr_cyc[0], 1);
    check("t5b_key", kwr_key[0], K2);
    check("t5b_done", d_cyc[0], 21);
    check("t5b_result", res[0], f(K2, D3, 1'b0));

    // Reset during DATA_WAIT.
    @(negedge clk);
    clear_log(); req[0] = 1'b1; data[KW-1:0] = D0; c0 = cyc;
    run(2'b00, -1, 0, 1'b0, '0, 5);
    check("t6_grant", g_cyc[0], 1);
    rst = 1'b1; req = 2'b00;
    #1;
    check_outputs_zero("t6_mid_reset");
    @(negedge clk);
    rst = 1'b0;
    clear_log(); req[0] = 1'b1; c0 = cyc;
    run(2'b00, -1, 0, 1'b0, '0, 30);
    check("t6_no_grant", g_cyc[0], -1);
    check("t6_no_done", d_cyc[0], -1);
    req = 2'b00;

    // ch1 without a key waits; key write plus held request grants on the same edge.
    clear_log(); req[1] = 1'b1; decipher[1] = 1'b0; data[2*KW-1:KW] = D4; c0 = cyc;
    run(2'b10, 5, 1, 1'b0, K1, 100);
    check("t4_grant", g_cyc[1], 6);
    check("t4_key", kwr_key[1], K1);
    check("t4_done", d_cyc[1], 26);
    check("t4_result", res[1], f(K1, D4, 1'b0));
    check("t4_ch0_idle", g_cyc[0], -1);

    // Fresh reset, then both channels at once: ch0 direct, ch1 indirect.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    write_key(0, 1'b0, K3);
    write_key(1, 1'b1, K4);
    for (int r = 0; r < 2; r++) begin
      clear_log(); req = 2'b11; decipher = 2'b10; data = {D6, D5}; c0 = cyc;
      run(2'b11, -1, 0, 1'b0, '0, 200);
      check("t3_grant0", g_cyc[0], 1);
      check("t3_grant1", g_cyc[1], 23);
      check("t3_keywr_n", kwr_n, 2);
      check("t3_done0", d_cyc[0], 21);
      check("t3_keymode1", kwr_mode[1], 1'b1);
      check("t3_key1", kwr_key[1], K4);
      check("t3_datawr1", dwr_cyc[1], 42);
      check("t3_done1", d_cyc[1], 61);
      check("t3_result0", res[0], f(K3, D5, 1'b0));
      check("t3_result1", res[1], f(K4, D6, 1'b1));
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
